bram_ctrl: RTL and testbench

Initiator-side controller for the single-port word BRAM used by the FIR tap and data buffers. It converts one-at-a-time word requests from a valid/ready command port into the BRAM's `EN`/`WE`/`A`/`Di` pin protocol. It tracks the BRAM's one-cycle registered-address read latency and returns read data or write completion on a valid/ready response port. It sits between the AXI-Lite/stream front-ends and the BRAM instance.

---
 rtl/bram_ctrl_pkg.sv | 19 +
 rtl/bram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bram_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_ctrl_pkg.sv
// bram_ctrl_pkg: shared state encoding and fixed widths for the word BRAM
// controller. The optional power-on clear sequence is enabled by defining
// BRAM_CTRL_CLEAR_EN.
package bram_ctrl_pkg;

    localparam int DEFAULT_WORDS = 11;
    localparam int STRB_W        = 4;
    localparam int DATA_W        = 32;
    localparam int ADDR_SHIFT    = 2;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCESS,
        ST_RDATA,
        ST_RESP
    } state_t;

endpackage

// File: rtl/bram_ctrl.sv
// bram_ctrl: initiator-side controller for a single-port word BRAM with a
// one-cycle registered-address read. It takes one word request at a time
// on a valid/ready command port and returns read data or write completion
// on a valid/ready response port.
// Optional feature: define BRAM_CTRL_CLEAR_EN to zero every word after reset
// before the first request is accepted.
module bram_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int WORDS  = DEFAULT_WORDS,
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              bram_en,
    output logic [STRB_W-1:0] bram_we,
    output logic [DATA_W-1:0] bram_di,
    output logic [ADDR_W-1:0] bram_a,
    input  logic [DATA_W-1:0] bram_do
);

    localparam logic [IDX_W:0] WORDS_LIM = (IDX_W+1)'(WORDS);

    state_t state;
    state_t state_next;

    logic req_in_range;
    logic we_q;
    logic in_range_q;

`ifdef BRAM_CTRL_CLEAR_EN
    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(WORDS - 1);
    logic [IDX_W-1:0] clr_idx;
`endif

    assign req_in_range = ({1'b0, req_idx} < WORDS_LIM);

    // State register; reset lands in CLEAR when the clear sequence is built in.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
`ifdef BRAM_CTRL_CLEAR_EN
            state <= ST_CLEAR;
`else
            state <= ST_IDLE;
`endif
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; req_ready and busy are pure state decodes gated by reset.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
`ifdef BRAM_CTRL_CLEAR_EN
            ST_CLEAR: begin
                if (clr_idx == CLR_LAST) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            ST_IDLE: begin
                req_ready = !RST;
                if (req_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_RDATA;
            end
            ST_RDATA: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy = (state != ST_IDLE) && !RST;
    end

    // BRAM pin registers and response registers, advanced per state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_di    <= '0;
            bram_a     <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef BRAM_CTRL_CLEAR_EN
            clr_idx    <= '0;
`endif
        end else begin
            case (state)
`ifdef BRAM_CTRL_CLEAR_EN
                ST_CLEAR: begin
                    bram_en <= 1'b1;
                    bram_we <= '1;
                    bram_di <= '0;
                    bram_a  <= ADDR_W'(clr_idx) << ADDR_SHIFT;
                    clr_idx <= clr_idx + 1'b1;
                end
`endif
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        in_range_q <= req_in_range;
                        bram_en    <= req_in_range;
                        bram_we    <= (req_in_range && req_we) ? req_strb : '0;
                        bram_di    <= req_wdata;
                        bram_a     <= ADDR_W'(req_idx) << ADDR_SHIFT;
                    end else begin
                        bram_en <= 1'b0;
                        bram_we <= '0;
                    end
                end
                ST_ACCESS: begin
                    bram_we <= '0;
                end
                ST_RDATA: begin
                    rsp_rdata <= (in_range_q && !we_q) ? bram_do : '0;
                    rsp_err   <= !in_range_q;
                    rsp_valid <= 1'b1;
                    bram_en   <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    bram_en <= 1'b0;
                    bram_we <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: drives bram_ctrl against a 12-word behavioural BRAM and a
// word-array reference model. Clear-sequence checks are compiled in when
// BRAM_CTRL_CLEAR_EN is defined.
module tb_bram_ctrl;

    localparam int WORDS    = 11;
    localparam int IDX_W    = 4;
    localparam int ADDR_W   = 12;
    localparam int MEM_SIZE = 12;

    logic              CLK;
    logic              RST;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [3:0]        req_strb;
    logic [IDX_W-1:0]  req_idx;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic [31:0]       bram_di;
    logic [ADDR_W-1:0] bram_a;
    logic [31:0]       bram_do;

    logic [31:0] mem [MEM_SIZE];
    logic [31:0] ref_mem [MEM_SIZE];

    int checks;
    int errors;

    bram_ctrl #(
        .WORDS (WORDS),
        .IDX_W (IDX_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_strb (req_strb),
        .req_idx  (req_idx),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_di  (bram_di),
        .bram_a   (bram_a),
        .bram_do  (bram_do)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural single-port BRAM: byte-enabled write, read-first registered output.
    always @(posedge CLK) begin
        if (bram_en) begin
            if (int'(bram_a >> 2) < MEM_SIZE) begin
                bram_do <= mem[int'(bram_a >> 2)];
                for (int b = 0; b < 4; b++) begin
                    if (bram_we[b]) begin
                        mem[int'(bram_a >> 2)][8*b +: 8] <= bram_di[8*b +: 8];
                    end
                end
            end else begin
                bram_do <= 32'h0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: a request either updates stored bytes or returns a stored word.
    task automatic modelExpect(input logic we, input logic [3:0] strb, input logic [IDX_W-1:0] idx,
                               input logic [31:0] wdata, output logic [31:0] exp_rdata, output logic exp_err);
        exp_err   = (int'(idx) >= WORDS);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) begin
                        ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end else begin
                exp_rdata = ref_mem[idx];
            end
        end
    endtask

    task automatic waitReady(input string tag);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput(tag, 32'(req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] strb, input logic [IDX_W-1:0] idx,
                                 input logic [31:0] wdata, input int hold, output logic [31:0] got_rdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        in_range;
        modelExpect(we, strb, idx, wdata, exp_rdata, exp_err);
        in_range = !exp_err;
        @(negedge CLK);
        waitReady("req_ready_idle");
        req_valid = 1'b1;
        req_we    = we;
        req_strb  = strb;
        req_idx   = idx;
        req_wdata = wdata;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_strb  = 4'($urandom);
        req_idx   = 4'($urandom);
        req_wdata = $urandom;
        checkOutput("access_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("access_bram_en", 32'(bram_en), 32'(in_range));
        checkOutput("access_bram_we", 32'(bram_we), 32'((in_range && we) ? strb : 4'h0));
        if (in_range) begin
            checkOutput("access_bram_a", 32'(bram_a), 32'(idx) << 2);
        end
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("rdata_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rdata_bram_en", 32'(bram_en), 32'(in_range));
        checkOutput("rdata_bram_we", 32'(bram_we), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("resp_bram_en", 32'(bram_en), 32'd0);
        checkOutput("resp_rdata", rsp_rdata, exp_rdata);
        checkOutput("resp_err", 32'(rsp_err), 32'(exp_err));
        got_rdata = rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_strb  = 4'hF;
            req_idx   = 4'($urandom_range(0, WORDS - 1));
            req_wdata = $urandom;
            rsp_ready = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rdata", rsp_rdata, exp_rdata);
            checkOutput("hold_err", 32'(rsp_err), 32'(exp_err));
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rsp_ready = 1'b0;
        checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("done_req_ready", 32'(req_ready), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic checkOutputsZero(input string tag);
        checkOutput(tag, 32'(|{req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
                                bram_en, bram_we, bram_di, bram_a}), 32'd0);
    endtask

    // Called at the instant reset is released.
    task automatic postReset();
`ifdef BRAM_CTRL_CLEAR_EN
        int busy_cycles;
        #1;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge CLK);
        end
        checkOutput("clear_busy_cycles", 32'(busy_cycles), 32'd11);
        for (int i = 0; i < WORDS; i++) begin
            ref_mem[i] = 32'h0;
        end
`else
        #1;
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_ready", 32'(req_ready), 32'd1);
`endif
    endtask

    task automatic resetMidWrite();
        @(negedge CLK);
        waitReady("rst_wr_ready");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_strb  = 4'hF;
        req_idx   = 4'd2;
        req_wdata = 32'h55;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        #1 RST = 1'b1;
        #1 checkOutputsZero("rst_mid_outputs");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        postReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("rst_no_response", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] got;
        logic        we;
        logic [IDX_W-1:0] idx;
        checks = 0;
        errors = 0;
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bram_do   = 32'h0;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_strb  = 4'h0;
        req_idx   = '0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutputsZero("reset_outputs");
        RST = 1'b0;
        postReset();

        $display("[TB] write/read");
        applyStimulus(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 0, got);
        applyStimulus(1'b0, 4'h0, 4'd3, 32'h0, 0, got);
        checkOutput("wr_rd_idx3", got, 32'hDEADBEEF);

        $display("[TB] byte strobe");
        applyStimulus(1'b1, 4'hF, 4'd5, 32'h11223344, 0, got);
        applyStimulus(1'b1, 4'h6, 4'd5, 32'hAABBCCDD, 0, got);
        applyStimulus(1'b0, 4'hF, 4'd5, 32'h0, 0, got);
        checkOutput("strb_idx5", got, 32'h11BBCC44);

        $display("[TB] out of range");
        applyStimulus(1'b0, 4'h0, 4'd12, 32'h0, 0, got);
        applyStimulus(1'b1, 4'hF, 4'd11, 32'h12345678, 0, got);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 4'h0, 4'd3, 32'h0, 5, got);
        applyStimulus(1'b0, 4'h0, 4'd5, 32'h0, 0, got);
        checkOutput("bp_no_accept", got, 32'h11BBCC44);

        $display("[TB] zero strobe write");
        applyStimulus(1'b1, 4'h0, 4'd3, 32'h01020304, 0, got);
        applyStimulus(1'b0, 4'h0, 4'd3, 32'h0, 0, got);
        checkOutput("strb0_idx3", got, 32'hDEADBEEF);

        $display("[TB] reset mid-write");
        applyStimulus(1'b1, 4'hF, 4'd2, 32'hCAFEF00D, 0, got);
        resetMidWrite();
        applyStimulus(1'b0, 4'h0, 4'd2, 32'h0, 0, got);

        $display("[TB] random traffic");
        for (int n = 0; n < 30; n++) begin
            we  = 1'($urandom);
            idx = 4'($urandom_range(0, 13));
            applyStimulus(we, 4'($urandom), idx, $urandom, int'($urandom_range(0, 2)), got);
        end

`ifdef BRAM_CTRL_CLEAR_EN
        $display("[TB] clear sequence");
        applyStimulus(1'b1, 4'hF, 4'd0, 32'hA5A5A5A5, 0, got);
        applyStimulus(1'b1, 4'hF, 4'd10, 32'h5A5A5A5A, 0, got);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        postReset();
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 0, got);
        checkOutput("clear_idx0", got, 32'h0);
        applyStimulus(1'b0, 4'h0, 4'd10, 32'h0, 0, got);
        checkOutput("clear_idx10", got, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
